cache_controller: RTL and testbench
===================================

# cache_controller

Direct-mapped, write-through, no-write-allocate data-cache controller between the CPU load/store port and the 4-word-block main memory. Holds tag/valid/data storage, detects hits, stalls the CPU on misses and all stores, and sequences the memory's multi-cycle read-block and write-word handshakes.

## Interface
- ADDR_W, 10, word address width (matches main memory)
- WORD_W, 32, data word width
- BLOCK_W, 128, memory block width (4 words)
- INDEX_W, 5, line index bits (32 lines); TAG_W = ADDR_W-INDEX_W-2
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- cpu_read  in  1  load request
- cpu_write  in  1  store request
- cpu_address  in  ADDR_W  word address {tag, index, offset[1:0]}
- cpu_data_in  in  WORD_W  store data
- cpu_data_out  out  WORD_W  load data
- stall  out  1  CPU must hold request, address and data while high
- mem_read  out  1  block read request to main memory
- mem_write  out  1  word write request to main memory
- mem_address  out  ADDR_W  memory address (= cpu_address)
- mem_data_out  out  WORD_W  memory write data (= cpu_data_in)
- mem_ready  in  1  memory completion pulse
- mem_block_data  in  BLOCK_W  block; word offset 0 in [127:96], offset 3 in [31:0]

## Operation
- States: IDLE, REFILL, WRITE.
- IDLE: hit = valid[index] && tag[index]==tag field.
  - cpu_write (priority when cpu_read also high): stall=1, next WRITE.
  - cpu_read && hit: stall=0, cpu_data_out = stored word; stay IDLE.
  - cpu_read && !hit: stall=1, next REFILL.
  - no request: stall=0.
- REFILL: mem_read=1, stall=1. On mem_ready=1: write full block into data[index], tag[index]<=tag field, valid[index]<=1 at that edge; next IDLE (access then hits, stall=0).
- WRITE: mem_write=1, stall=1. On mem_ready=1: if line hits, replace addressed word in data[index] at that edge (write hit); on miss cache untouched (no allocate); next IDLE, stall=0 that cycle with no new request outstanding.
- mem_read and mem_write never both high; both decoded from state only (Moore).
- mem_ready outside REFILL/WRITE ignored.
- cpu_data_out: combinational word select by offset from data[index] when valid[index]; 0 when line invalid.
- Reset: state IDLE, all valid bits 0; tag/data arrays not reset.

## Timing
- Read hit: 0 stall cycles, data same cycle.
- Miss/store: stall high from detect cycle through the cycle mem_ready is sampled; next cycle stall=0. With the team's memory (ready on 4th edge after request sampled): detect cycle 0, REFILL/WRITE cycles 1-5, ready seen cycle 5, stall low cycle 6 (6 stall cycles).
- Request outputs asserted from first cycle in wait state to cycle mem_ready sampled inclusive, low the cycle after.
- Reset mid-REFILL/WRITE: next cycle IDLE, mem_read=mem_write=0, stall=0, no array update from that transaction.
- Reset values: stall=0, mem_read=0, mem_write=0, cpu_data_out=0; mem_address/mem_data_out follow CPU inputs.

## Structure
- Package cache_pkg: state enum {IDLE, REFILL, WRITE}; width localparams (OFFSET_W=2, INDEX_W, TAG_W); word-lane select function (offset -> bit range, offset 0 = MSB word).
- Sub-module cache_line_store: tag/valid/data arrays, block fill and single-word write ports, combinational lookup; controller FSM in top.

## Test plan
- Reset, cpu_read addr 0x004 -> stall 6 cycles, mem_read cycles 1-5, then data = memory word 0x004 (preloaded 0xDEADBEEF) with stall=0.
- Re-read 0x005 after fill -> hit, stall=0, data = mem word 0x005, mem_read stays 0.
- Store 0xA5A5A5A5 to cached 0x006 -> mem_write cycles 1-5, then load 0x006 hits returning 0xA5A5A5A5, memory word 0x006 = 0xA5A5A5A5.
- Store to uncached 0x3F0 -> memory updated, following load 0x3F0 misses (REFILL) then returns stored value.
- Conflict: load 0x004 then 0x084 (same index, tag differs) -> second misses and evicts; reload 0x004 misses again.
- cpu_read and cpu_write both high -> WRITE taken; assert rst low in cycle 3 of REFILL -> next cycle IDLE, all outputs at reset values, line remains invalid.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared widths, FSM state type and word-lane helper for the direct-mapped
// write-through data cache.
package cache_pkg;

   localparam int ADDR_W      = 10;
   localparam int WORD_W      = 32;
   localparam int BLOCK_W     = 128;
   localparam int OFFSET_W    = 2;
   localparam int INDEX_W     = 5;
   localparam int TAG_W       = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINES       = 1 << INDEX_W;
   localparam int BLOCK_IDX_W = $clog2(BLOCK_W);
   localparam int WORD_IDX_W  = $clog2(WORD_W);

   typedef enum logic [1:0] {
      IDLE,
      REFILL,
      WRITE
   } state_t;

   // Offset 0 is the most significant word of a block, so the LSB of a lane is (3 - offset) * 32.
   function automatic logic [BLOCK_IDX_W-1:0] lane_lsb(input logic [OFFSET_W-1:0] offset);
      lane_lsb = {~offset, {WORD_IDX_W{1'b0}}};
   endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU load/store port and main-memory port of the cache controller.
// The master modport is the controller's view; slave is the CPU/memory side.
interface cache_controller_if;
   import cache_pkg::*;

   logic                cpu_read;
   logic                cpu_write;
   logic [ADDR_W-1:0]   cpu_address;
   logic [WORD_W-1:0]   cpu_data_in;
   logic [WORD_W-1:0]   cpu_data_out;
   logic                stall;
   logic                mem_read;
   logic                mem_write;
   logic [ADDR_W-1:0]   mem_address;
   logic [WORD_W-1:0]   mem_data_out;
   logic                mem_ready;
   logic [BLOCK_W-1:0]  mem_block_data;

   modport master (
      input  cpu_read, cpu_write, cpu_address, cpu_data_in, mem_ready, mem_block_data,
      output cpu_data_out, stall, mem_read, mem_write, mem_address, mem_data_out
   );

   modport slave (
      output cpu_read, cpu_write, cpu_address, cpu_data_in, mem_ready, mem_block_data,
      input  cpu_data_out, stall, mem_read, mem_write, mem_address, mem_data_out
   );

endinterface

// File: rtl/cache_line_store.sv
// Tag/valid/data storage for 32 lines of 4 words, with a whole-block fill
// port, a single-word write port and a combinational hit/word lookup.
module cache_line_store
   import cache_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [INDEX_W-1:0]  index,
   input  logic [TAG_W-1:0]    tag,
   input  logic [OFFSET_W-1:0] offset,
   input  logic                fill_en,
   input  logic [BLOCK_W-1:0]  fill_data,
   input  logic                word_en,
   input  logic [WORD_W-1:0]   word_data,
   output logic                hit,
   output logic [WORD_W-1:0]   read_word
);

   logic [BLOCK_W-1:0] data_mem [LINES];
   logic [TAG_W-1:0]   tag_mem  [LINES];
   logic [LINES-1:0]   valid;

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid <= '0;
      end else if (fill_en) begin
         valid[index] <= 1'b1;
      end
   end

   // Tags and data are only meaningful behind a valid bit, so they carry no reset.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         data_mem[index] <= fill_data;
         tag_mem[index]  <= tag;
      end else if (word_en) begin
         data_mem[index][lane_lsb(offset) +: WORD_W] <= word_data;
      end
   end

   assign hit       = valid[index] && (tag_mem[index] == tag);
   assign read_word = valid[index] ? data_mem[index][lane_lsb(offset) +: WORD_W] : '0;

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller.
// Stalls the CPU on misses and on every store while memory completes.
module cache_controller
   import cache_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   cache_controller_if.master bus
);

   state_t                state;
   logic                  mem_read_q;
   logic                  mem_write_q;
   logic                  write_done;
   logic                  hit;
   logic                  stall_c;
   logic                  fill_en;
   logic                  word_en;
   logic [TAG_W-1:0]      tag;
   logic [INDEX_W-1:0]    index;
   logic [OFFSET_W-1:0]   offset;

   assign tag    = bus.cpu_address[ADDR_W-1 -: TAG_W];
   assign index  = bus.cpu_address[OFFSET_W +: INDEX_W];
   assign offset = bus.cpu_address[OFFSET_W-1:0];

   // An aborted transaction must not touch the arrays, so updates are gated by reset.
   assign fill_en = rst && (state == REFILL) && bus.mem_ready;
   assign word_en = rst && (state == WRITE) && bus.mem_ready && hit;

   cache_line_store u_store (
      .clk       (clk),
      .rst       (rst),
      .index     (index),
      .tag       (tag),
      .offset    (offset),
      .fill_en   (fill_en),
      .fill_data (bus.mem_block_data),
      .word_en   (word_en),
      .word_data (bus.cpu_data_in),
      .hit       (hit),
      .read_word (bus.cpu_data_out)
   );

   // write_done marks the cycle after a store completes, when the CPU still holds the old request.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         write_done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               write_done <= 1'b0;
               if (!write_done) begin
                  if (bus.cpu_write) begin
                     state       <= WRITE;
                     mem_write_q <= 1'b1;
                  end else if (bus.cpu_read && !hit) begin
                     state      <= REFILL;
                     mem_read_q <= 1'b1;
                  end
               end
            end
            REFILL: begin
               if (bus.mem_ready) begin
                  state      <= IDLE;
                  mem_read_q <= 1'b0;
               end
            end
            WRITE: begin
               if (bus.mem_ready) begin
                  state       <= IDLE;
                  mem_write_q <= 1'b0;
                  write_done  <= 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               mem_read_q  <= 1'b0;
               mem_write_q <= 1'b0;
               write_done  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      stall_c = 1'b1;
      if (state == IDLE) begin
         stall_c = !write_done && (bus.cpu_write || (bus.cpu_read && !hit));
      end
      if (!rst) begin
         stall_c = 1'b0;
      end
   end

   assign bus.stall        = stall_c;
   assign bus.mem_read     = mem_read_q;
   assign bus.mem_write    = mem_write_q;
   assign bus.mem_address  = bus.cpu_address;
   assign bus.mem_data_out = bus.cpu_data_in;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a 4-edge-latency main memory model.
// Memory word i holds 0x10000000|i except word 0x004 = 0xDEADBEEF.
module tb_cache_controller;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   cache_controller_if bus ();

   cache_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [1024];
   bit          mem_loaded = 1'b0;
   int          mem_cnt;

   assign bus.mem_block_data = {mem[{bus.mem_address[9:2], 2'b00}], mem[{bus.mem_address[9:2], 2'b01}],
                                mem[{bus.mem_address[9:2], 2'b10}], mem[{bus.mem_address[9:2], 2'b11}]};

   // Ready rises on the 4th edge that sees a request and lasts one cycle; writes land at that cycle's end.
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'h1000_0000 | i;
         mem[4]     <= 32'hDEAD_BEEF;
         mem_loaded <= 1'b1;
      end
      if (!rst) begin
         mem_cnt       <= 0;
         bus.mem_ready <= 1'b0;
      end else if (bus.mem_ready) begin
         bus.mem_ready <= 1'b0;
         mem_cnt       <= 0;
         if (bus.mem_write) mem[bus.mem_address] <= bus.mem_data_out;
      end else if (bus.mem_read || bus.mem_write) begin
         if (mem_cnt == 3) bus.mem_ready <= 1'b1;
         else mem_cnt <= mem_cnt + 1;
      end
   end

   task automatic apply_stimulus(input logic rd, input logic wr, input logic [9:0] addr,
                                 input logic [31:0] wdata, output int stalls, output int rds,
                                 output int wrs, output int first_req, output logic [31:0] rdata);
      bit done;
      done = 1'b0; stalls = 0; rds = 0; wrs = 0; first_req = -1; rdata = 'x;
      bus.cpu_read = rd; bus.cpu_write = wr; bus.cpu_address = addr; bus.cpu_data_in = wdata;
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         if (bus.mem_read === 1'b1) begin rds++; if (first_req < 0) first_req = c; end
         if (bus.mem_write === 1'b1) begin wrs++; if (first_req < 0) first_req = c; end
         if (bus.stall === 1'b0) begin
            rdata = bus.cpu_data_out;
            done  = 1'b1;
         end else begin
            stalls++;
            @(posedge clk);
         end
      end
      @(posedge clk); #1;
      bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
      bus.cpu_address = 10'h155; bus.cpu_data_in = 32'h1357_9BDF;
      repeat (2) @(posedge clk);
      #1;
      tests_run++; if (bus.stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall); end
      tests_run++; if (bus.mem_read !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_read: got %b expected 0", bus.mem_read); end
      tests_run++; if (bus.mem_write !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_write: got %b expected 0", bus.mem_write); end
      tests_run++; if (bus.cpu_data_out !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_data_out: got %h expected 0", bus.cpu_data_out); end
      tests_run++; if (bus.mem_address !== 10'h155) begin tests_failed++; $display("[TB] FAIL reset_mem_address: got %h expected 155", bus.mem_address); end
      tests_run++; if (bus.mem_data_out !== 32'h1357_9BDF) begin tests_failed++; $display("[TB] FAIL reset_mem_data_out: got %h expected 13579bdf", bus.mem_data_out); end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_read_miss();
      int s, r, w, f; logic [31:0] q;
      apply_stimulus(1'b1, 1'b0, 10'h004, 32'h0, s, r, w, f, q);
      tests_run++; if (s !== 6) begin tests_failed++; $display("[TB] FAIL miss_stall_cycles: got %0d expected 6", s); end
      tests_run++; if (r !== 5) begin tests_failed++; $display("[TB] FAIL miss_mem_read_cycles: got %0d expected 5", r); end
      tests_run++; if (f !== 1) begin tests_failed++; $display("[TB] FAIL miss_first_request_cycle: got %0d expected 1", f); end
      tests_run++; if (q !== 32'hDEAD_BEEF) begin tests_failed++; $display("[TB] FAIL miss_data: got %h expected deadbeef", q); end
      tests_run++; if (bus.mem_read !== 1'b0) begin tests_failed++; $display("[TB] FAIL miss_mem_read_after: got %b expected 0", bus.mem_read); end
   endtask

   task automatic test_read_hit();
      int s, r, w, f; logic [31:0] q;
      apply_stimulus(1'b1, 1'b0, 10'h005, 32'h0, s, r, w, f, q);
      tests_run++; if (s !== 0) begin tests_failed++; $display("[TB] FAIL hit_stall_cycles: got %0d expected 0", s); end
      tests_run++; if (r !== 0) begin tests_failed++; $display("[TB] FAIL hit_mem_read_cycles: got %0d expected 0", r); end
      tests_run++; if (q !== 32'h1000_0005) begin tests_failed++; $display("[TB] FAIL hit_data: got %h expected 10000005", q); end
   endtask

   task automatic test_write_hit();
      int s, r, w, f; logic [31:0] q;
      apply_stimulus(1'b0, 1'b1, 10'h006, 32'hA5A5_A5A5, s, r, w, f, q);
      tests_run++; if (s !== 6) begin tests_failed++; $display("[TB] FAIL wrhit_stall_cycles: got %0d expected 6", s); end
      tests_run++; if (w !== 5 || r !== 0) begin tests_failed++; $display("[TB] FAIL wrhit_mem_cycles: got write %0d read %0d expected 5 and 0", w, r); end
      tests_run++; if (f !== 1) begin tests_failed++; $display("[TB] FAIL wrhit_first_request_cycle: got %0d expected 1", f); end
      tests_run++; if (mem[10'h006] !== 32'hA5A5_A5A5) begin tests_failed++; $display("[TB] FAIL wrhit_memory: got %h expected a5a5a5a5", mem[10'h006]); end
      apply_stimulus(1'b1, 1'b0, 10'h006, 32'h0, s, r, w, f, q);
      tests_run++; if (s !== 0 || q !== 32'hA5A5_A5A5) begin tests_failed++; $display("[TB] FAIL wrhit_reload: got stall %0d data %h expected 0 and a5a5a5a5", s, q); end
      apply_stimulus(1'b1, 1'b0, 10'h007, 32'h0, s, r, w, f, q);
      tests_run++; if (s !== 0 || q !== 32'h1000_0007) begin tests_failed++; $display("[TB] FAIL wrhit_neighbour: got stall %0d data %h expected 0 and 10000007", s, q); end
   endtask

   task automatic test_write_miss();
      int s, r, w, f; logic [31:0] q;
      apply_stimulus(1'b0, 1'b1, 10'h3F0, 32'h1234_5678, s, r, w, f, q);
      tests_run++; if (s !== 6 || w !== 5) begin tests_failed++; $display("[TB] FAIL wrmiss_cycles: got stall %0d write %0d expected 6 and 5", s, w); end
      tests_run++; if (mem[10'h3F0] !== 32'h1234_5678) begin tests_failed++; $display("[TB] FAIL wrmiss_memory: got %h expected 12345678", mem[10'h3F0]); end
      apply_stimulus(1'b1, 1'b0, 10'h3F0, 32'h0, s, r, w, f, q);
      tests_run++; if (s !== 6 || r !== 5) begin tests_failed++; $display("[TB] FAIL wrmiss_no_allocate: got stall %0d read %0d expected 6 and 5", s, r); end
      tests_run++; if (q !== 32'h1234_5678) begin tests_failed++; $display("[TB] FAIL wrmiss_reload_data: got %h expected 12345678", q); end
   endtask

   task automatic test_conflict();
      int s, r, w, f; logic [31:0] q;
      apply_stimulus(1'b1, 1'b0, 10'h004, 32'h0, s, r, w, f, q);
      tests_run++; if (s !== 0 || q !== 32'hDEAD_BEEF) begin tests_failed++; $display("[TB] FAIL conflict_first_hit: got stall %0d data %h expected 0 and deadbeef", s, q); end
      apply_stimulus(1'b1, 1'b0, 10'h084, 32'h0, s, r, w, f, q);
      tests_run++; if (s !== 6 || q !== 32'h1000_0084) begin tests_failed++; $display("[TB] FAIL conflict_evict: got stall %0d data %h expected 6 and 10000084", s, q); end
      apply_stimulus(1'b1, 1'b0, 10'h004, 32'h0, s, r, w, f, q);
      tests_run++; if (s !== 6 || q !== 32'hDEAD_BEEF) begin tests_failed++; $display("[TB] FAIL conflict_reload: got stall %0d data %h expected 6 and deadbeef", s, q); end
   endtask

   task automatic test_read_write_both();
      int s, r, w, f; logic [31:0] q;
      apply_stimulus(1'b1, 1'b1, 10'h010, 32'hCAFE_F00D, s, r, w, f, q);
      tests_run++; if (w !== 5 || r !== 0) begin tests_failed++; $display("[TB] FAIL both_write_priority: got write %0d read %0d expected 5 and 0", w, r); end
      tests_run++; if (s !== 6) begin tests_failed++; $display("[TB] FAIL both_stall_cycles: got %0d expected 6", s); end
      tests_run++; if (mem[10'h010] !== 32'hCAFE_F00D) begin tests_failed++; $display("[TB] FAIL both_memory: got %h expected cafef00d", mem[10'h010]); end
   endtask

   task automatic test_reset_mid_refill();
      int s, r, w, f; logic [31:0] q;
      bus.cpu_read = 1'b1; bus.cpu_write = 1'b0; bus.cpu_address = 10'h200;
      #1;
      tests_run++; if (bus.stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL abort_detect_stall: got %b expected 1", bus.stall); end
      repeat (3) @(posedge clk);
      #1;
      tests_run++; if (bus.mem_read !== 1'b1) begin tests_failed++; $display("[TB] FAIL abort_refill_active: got %b expected 1", bus.mem_read); end
      rst = 1'b0; bus.cpu_read = 1'b0;
      @(posedge clk); #1;
      tests_run++; if (bus.stall !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
         tests_failed++; $display("[TB] FAIL abort_outputs: got stall %b read %b write %b expected 0 0 0", bus.stall, bus.mem_read, bus.mem_write);
      end
      tests_run++; if (bus.cpu_data_out !== 32'h0) begin tests_failed++; $display("[TB] FAIL abort_data_out: got %h expected 0", bus.cpu_data_out); end
      rst = 1'b1;
      @(posedge clk); #1;
      apply_stimulus(1'b1, 1'b0, 10'h200, 32'h0, s, r, w, f, q);
      tests_run++; if (s !== 6 || q !== 32'h1000_0200) begin tests_failed++; $display("[TB] FAIL abort_line_invalid: got stall %0d data %h expected 6 and 10000200", s, q); end
      apply_stimulus(1'b1, 1'b0, 10'h004, 32'h0, s, r, w, f, q);
      tests_run++; if (s !== 6 || q !== 32'hDEAD_BEEF) begin tests_failed++; $display("[TB] FAIL abort_valid_cleared: got stall %0d data %h expected 6 and deadbeef", s, q); end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_read_miss();
      test_read_hit();
      test_write_hit();
      test_write_miss();
      test_conflict();
      test_read_write_both();
      test_reset_mid_refill();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
